// File: rtl/epu_dma_master.sv
// AXI4 DMA initiator: reads INCR bursts from memory into a local buffer, then writes each
// burst to the fixed EPU raw-data address until the requested word count has been moved.
module epu_dma_master #(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    localparam int IW = ($clog2(MAX_BURST) > 0) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_src_q, cur_src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] remaining_q, remaining_d;
    logic [4:0]  rcnt_q, rcnt_d;
    logic [4:0]  wcnt_q, wcnt_d;
    logic        rd_bad_q, rd_bad_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic [31:0] data_buf_q [0:(1<<IW)-1];
    logic        buf_we;
    logic        beat_bad;
    logic [4:0]  beats;
    logic [4:0]  last_idx;

    assign beats    = (remaining_q > 16'(MAX_BURST)) ? 5'(MAX_BURST) : remaining_q[4:0];
    assign last_idx = beats - 5'd1;

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        rd_bad_d    = rd_bad_q;
        err_d       = err_q;
        buf_we      = 1'b0;
        beat_bad    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (word_cnt != 16'd0) begin
                        cur_src_d   = {src_addr[31:2], 2'b00};
                        dst_d       = dst_addr;
                        remaining_d = word_cnt;
                        state_d     = RD_ADDR;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && ARREADY) begin
                    rcnt_d   = 5'd0;
                    rd_bad_d = 1'b0;
                    state_d  = RD_DATA;
                end
            end
            RD_DATA: begin
                // A faulty burst is drained to RLAST but never written out.
                if (rready_q && RVALID) begin
                    beat_bad = (RRESP != 2'b00) || (RLAST != (rcnt_q == last_idx));
                    buf_we   = !rd_bad_q && !beat_bad;
                    rcnt_d   = rcnt_q + 5'd1;
                    if (beat_bad) begin
                        err_d    = 1'b1;
                        rd_bad_d = 1'b1;
                    end
                    if (RLAST) begin
                        state_d = (rd_bad_q || beat_bad) ? FIN : WR_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (awvalid_q && AWREADY) begin
                    wcnt_d  = 5'd0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (wvalid_q && WREADY) begin
                    wcnt_d = wcnt_q + 5'd1;
                    if (wcnt_q == last_idx) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready_q && BVALID) begin
                    if (BRESP != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        remaining_d = remaining_q - 16'(beats);
                        cur_src_d   = cur_src_q + 32'({beats, 2'b00});
                        state_d     = (remaining_q == 16'(beats)) ? FIN : RD_ADDR;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        awvalid_d = (state_d == WR_ADDR);
        wvalid_d  = (state_d == WR_DATA);
        bready_d  = (state_d == WR_RESP);
        done_d    = (state_d == FIN);
        busy_d    = (state_d inside {RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP}) ||
                    ((state_d == FIN) && busy_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_src_q   <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            rd_bad_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            rd_bad_q    <= rd_bad_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            data_buf_q[rcnt_q[IW-1:0]] <= RDATA;
        end
    end

    assign ARID    = AXI_ID;
    assign ARADDR  = cur_src_q;
    assign ARLEN   = last_idx[3:0];
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
    assign AWID    = AXI_ID;
    assign AWADDR  = dst_q;
    assign AWLEN   = last_idx[3:0];
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;
    assign WDATA   = data_buf_q[wcnt_q[IW-1:0]];
    assign WSTRB   = 4'hF;
    assign WLAST   = (wcnt_q == last_idx);
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    logic unused_ok;
    assign unused_ok = ^{RID, BID, src_addr[1:0]};

endmodule

// File: tb/tb_epu_dma_master.sv
// Directed bench for epu_dma_master: a behavioural AXI memory/EPU slave with stall and
// error injection, a table of transfer vectors, and hand-written corner-case sequences.
module tb_epu_dma_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] word_cnt;
   logic        busy, done, err;
   logic [3:0]  ARID, ARLEN, RID, AWID, AWLEN, WSTRB, BID;
   logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

   always #5 clk = ~clk;

   epu_dma_master #(.MAX_BURST(16), .AXI_ID(4'd1)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   int nCompared = 0;
   int nMismatched = 0;

   // Slave configuration, written only by the main sequence.
   int errBurst = -1;
   int errBeat = 0;
   int stallAt = -1;
   int stallLen = 0;

   // Logs and monitor state, written only by the slave process.
   int cyc, nAr, nAw, nW, nB, nDone, doneCyc, bCyc, startCyc, stallCycles, unstable;
   bit arSeen, awSeen, busySeen, doneWide, prevDone, inStall;
   logic [31:0] arAddrLog [8];
   logic [3:0]  arLenLog [8];
   logic [31:0] awAddrLog [8];
   logic [3:0]  awLenLog [8];
   logic [31:0] wLog [64];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Behavioural slave: samples handshakes at the falling edge, updates its outputs
   // just after the following rising edge.
   initial begin : slave
      logic        sAr, sR, sRlast, sAw, sW, sWlast, sB;
      logic [31:0] sArAddr, sAwAddr, sWdata, stData, rdAddr;
      logic [3:0]  sArLen, sAwLen;
      logic        stLast;
      int          rdBeat, rdLen, rdBurst, stallLeft;
      bit          stallDone;
      ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
      RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = 4'd1;
      BVALID = 1'b0; BRESP = 2'b00; BID = 4'd1;
      cyc = 0; nAr = 0; nAw = 0; nW = 0; nB = 0; nDone = 0; doneCyc = -10; bCyc = -10;
      startCyc = -10; stallCycles = 0; unstable = 0;
      arSeen = 0; awSeen = 0; busySeen = 0; doneWide = 0; prevDone = 0; inStall = 0;
      rdAddr = '0; rdBeat = 0; rdLen = 0; rdBurst = 0; stallLeft = 0; stallDone = 0;
      stData = '0; stLast = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         sAr = ARVALID && ARREADY; sArAddr = ARADDR; sArLen = ARLEN;
         sR = RVALID && RREADY; sRlast = RLAST;
         sAw = AWVALID && AWREADY; sAwAddr = AWADDR; sAwLen = AWLEN;
         sW = WVALID && WREADY; sWdata = WDATA; sWlast = WLAST;
         sB = BVALID && BREADY;
         if (start && !busy && !rst) begin
            nAr = 0; nAw = 0; nW = 0; nB = 0; nDone = 0; doneCyc = -10; bCyc = -10;
            startCyc = cyc; stallCycles = 0; unstable = 0; stallDone = 0;
            arSeen = 0; awSeen = 0; busySeen = 0; doneWide = 0;
         end
         if (ARVALID) arSeen = 1;
         if (AWVALID) awSeen = 1;
         if (busy) busySeen = 1;
         if (done) begin
            nDone++;
            doneCyc = cyc;
            if (prevDone) doneWide = 1;
         end
         prevDone = done;
         if (WVALID && !WREADY) begin
            if (!inStall) begin
               inStall = 1; stData = WDATA; stLast = WLAST;
            end else if (WDATA !== stData || WLAST !== stLast) begin
               unstable++;
            end
            stallCycles++;
         end else begin
            inStall = 0;
         end
         if (sB) bCyc = cyc;

         @(posedge clk);
         #1;
         if (rst) begin
            RVALID = 1'b0; RLAST = 1'b0; BVALID = 1'b0; WREADY = 1'b1; stallLeft = 0;
         end else begin
            if (sAr) begin
               if (nAr < 8) begin
                  arAddrLog[nAr] = sArAddr; arLenLog[nAr] = sArLen;
               end
               rdAddr = sArAddr; rdBeat = 0; rdLen = int'(sArLen); rdBurst = nAr;
               nAr++;
            end else if (sR) begin
               rdBeat++;
            end
            if (sAr || (sR && !sRlast)) begin
               RVALID = 1'b1;
               RDATA  = memWord(rdAddr + 32'(rdBeat * 4));
               RLAST  = (rdBeat == rdLen);
               RRESP  = (rdBurst == errBurst && rdBeat == errBeat) ? 2'b10 : 2'b00;
            end else if (sR) begin
               RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            end
            if (sAw) begin
               if (nAw < 8) begin
                  awAddrLog[nAw] = sAwAddr; awLenLog[nAw] = sAwLen;
               end
               nAw++;
            end
            if (sW) begin
               if (nW < 64) wLog[nW] = sWdata;
               nW++;
               if (sWlast) begin
                  BVALID = 1'b1; BRESP = 2'b00;
               end
            end
            if (sB) begin
               BVALID = 1'b0; nB++;
            end
            if (stallLeft > 0) begin
               stallLeft--;
               if (stallLeft == 0) WREADY = 1'b1;
            end else if (!stallDone && stallAt >= 0 && nW == stallAt) begin
               WREADY = 1'b0; stallLeft = stallLen; stallDone = 1;
            end
         end
      end
   end

   task automatic pulseStart(input logic [15:0] c, input logic [31:0] s, output logic busyAfter);
      @(posedge clk); #1;
      word_cnt = c; src_addr = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busyAfter = busy;
   endtask

   task automatic waitDone(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #2;
   endtask

   task automatic applyStimulus(input logic [15:0] c, input logic [31:0] s,
                                output logic busyAfter, output logic ok);
      pulseStart(c, s, busyAfter);
      waitDone(ok);
   endtask

   task automatic checkWords(input string name, input int n, input logic [31:0] base);
      int bad;
      bad = 0;
      for (int k = 0; k < n && k < 64; k++) begin
         if (wLog[k] !== memWord(base + 32'(k * 4))) bad++;
      end
      checkOutput($sformatf("%s_wcount", name), 32'(nW), 32'(n));
      checkOutput($sformatf("%s_wdata_bad", name), 32'(bad), 32'd0);
   endtask

   typedef struct {
      logic [15:0] cnt;
      logic [31:0] src;
      int          expAr;
      logic [31:0] expLastAddr;
      logic [3:0]  expLastLen;
   } vec_t;

   vec_t vecs [4];

   initial begin : main
      logic busyAfter, ok;
      logic [31:0] srcAl;
      vecs[0] = '{16'd4,  32'h0000_1000, 1, 32'h0000_1000, 4'd3};
      vecs[1] = '{16'd37, 32'h0000_1000, 3, 32'h0000_1080, 4'd4};
      vecs[2] = '{16'd16, 32'h0000_2003, 1, 32'h0000_2000, 4'd15};
      vecs[3] = '{16'd17, 32'hFFFF_FFC0, 2, 32'h0000_0000, 4'd0};

      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = 32'h0010_0000; word_cnt = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_handshakes", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
      checkOutput("reset_status", 32'({busy, done, err}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].cnt, vecs[v].src, busyAfter, ok);
         srcAl = {vecs[v].src[31:2], 2'b00};
         $display("[TB] vector %0d: %0d words from 0x%08h", v, vecs[v].cnt, vecs[v].src);
         checkOutput($sformatf("v%0d_done_seen", v), 32'(ok), 32'd1);
         checkOutput($sformatf("v%0d_busy_after_start", v), 32'(busyAfter), 32'd1);
         checkOutput($sformatf("v%0d_ar_count", v), 32'(nAr), 32'(vecs[v].expAr));
         checkOutput($sformatf("v%0d_aw_count", v), 32'(nAw), 32'(vecs[v].expAr));
         for (int k = 0; k < vecs[v].expAr && k < nAr && k < 8; k++) begin
            checkOutput($sformatf("v%0d_araddr%0d", v, k), arAddrLog[k], srcAl + 32'(k * 64));
            checkOutput($sformatf("v%0d_arlen%0d", v, k), 32'(arLenLog[k]),
                        (k == vecs[v].expAr - 1) ? 32'(vecs[v].expLastLen) : 32'd15);
            if (k < nAw) begin
               checkOutput($sformatf("v%0d_awaddr%0d", v, k), awAddrLog[k], 32'h0010_0000);
               checkOutput($sformatf("v%0d_awlen%0d", v, k), 32'(awLenLog[k]), 32'(arLenLog[k]));
            end
         end
         if (nAr > 0 && nAr <= 8) begin
            checkOutput($sformatf("v%0d_last_araddr", v), arAddrLog[nAr-1], vecs[v].expLastAddr);
         end
         checkWords($sformatf("v%0d", v), int'(vecs[v].cnt), srcAl);
         checkOutput($sformatf("v%0d_err", v), 32'(err), 32'd0);
         checkOutput($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
         checkOutput($sformatf("v%0d_done_after_b", v), 32'(doneCyc), 32'(bCyc + 1));
         checkOutput($sformatf("v%0d_done_pulses", v), 32'({doneWide, 8'(nDone)}), 32'd1);
      end

      // WREADY stalled for 20 cycles on the third beat.
      stallAt = 2; stallLen = 20;
      applyStimulus(16'd4, 32'h0000_1000, busyAfter, ok);
      stallAt = -1;
      checkOutput("stall_done_seen", 32'(ok), 32'd1);
      checkOutput("stall_cycles", 32'(stallCycles), 32'd20);
      checkOutput("stall_unstable", 32'(unstable), 32'd0);
      checkWords("stall", 4, 32'h0000_1000);

      // SLVERR on beat 1 of the second read burst.
      errBurst = 1; errBeat = 1;
      applyStimulus(16'd37, 32'h0000_1000, busyAfter, ok);
      errBurst = -1;
      checkOutput("slverr_done_seen", 32'(ok), 32'd1);
      checkOutput("slverr_err", 32'(err), 32'd1);
      checkOutput("slverr_ar_count", 32'(nAr), 32'd2);
      checkOutput("slverr_aw_count", 32'(nAw), 32'd1);
      checkOutput("slverr_w_count", 32'(nW), 32'd16);
      checkOutput("slverr_busy_end", 32'(busy), 32'd0);
      checkOutput("slverr_done_pulses", 32'(nDone), 32'd1);

      // Zero-length request: no bus traffic, busy never rises, done one cycle later.
      applyStimulus(16'd0, 32'h0000_7000, busyAfter, ok);
      checkOutput("zero_done_seen", 32'(ok), 32'd1);
      checkOutput("zero_busy_after_start", 32'(busyAfter), 32'd0);
      checkOutput("zero_bus_traffic", 32'({arSeen, awSeen}), 32'd0);
      checkOutput("zero_busy_seen", 32'(busySeen), 32'd0);
      checkOutput("zero_done_latency", 32'(doneCyc), 32'(startCyc + 1));
      checkOutput("zero_err_cleared", 32'(err), 32'd0);

      // A second start while busy must be ignored.
      pulseStart(16'd4, 32'h0000_3000, busyAfter);
      repeat (3) @(posedge clk);
      pulseStart(16'd37, 32'h0000_5000, busyAfter);
      waitDone(ok);
      repeat (5) @(negedge clk);
      checkOutput("ignore_done_seen", 32'(ok), 32'd1);
      checkOutput("ignore_ar_count", 32'(nAr), 32'd1);
      checkOutput("ignore_araddr", arAddrLog[0], 32'h0000_3000);
      checkWords("ignore", 4, 32'h0000_3000);
      checkOutput("ignore_busy_end", 32'(busy), 32'd0);

      // Asynchronous reset while the write burst is stalled mid-way.
      stallAt = 5; stallLen = 30;
      pulseStart(16'd16, 32'h0000_1000, busyAfter);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (WVALID && nW >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("rst_reached_wdata", 32'(ok), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_outputs", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, done}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stallAt = -1;
      applyStimulus(16'd4, 32'h0000_1000, busyAfter, ok);
      checkOutput("post_rst_done_seen", 32'(ok), 32'd1);
      checkOutput("post_rst_ar_count", 32'(nAr), 32'd1);
      checkWords("post_rst", 4, 32'h0000_1000);
      checkOutput("post_rst_err", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
